// File: rtl/pwm_capture.sv
// pwm_capture
//   Samples an external PWM waveform and measures, in clock cycles, the
//   rise-to-rise period and the high time of each complete period. The duty
//   cycle is quantised onto the 0..4 brightness scale of the LED PWM
//   generator. One result is published per period with a one-cycle strobe.
//   A line with no rising edge for TIMEOUT cycles produces a stuck result
//   instead, repeated every TIMEOUT+1 cycles while the line stays static.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset, clears every register
//   pwm_in      in   asynchronous PWM waveform
//   valid       out  one-cycle strobe; level/high_cnt/period_cnt/stuck are new
//   level       out  quantised duty 0..4 (4 only for a stuck-high line)
//   high_cnt    out  high time of the last complete period, cycles
//   period_cnt  out  rise-to-rise period, cycles
//   stuck       out  1 = the last result was a timeout event
//
// Latency: pwm_in rising before edge n gives valid high after edge n+4.
module pwm_capture #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic             valid,
  output logic [2:0]       level,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             stuck
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam int               PW       = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_ONE;
  endfunction

  // Largest k in 0..3 with 4*hi >= k*per. All products fit in PW bits.
  function automatic logic [1:0] quant_level(input logic [CNT_W-1:0] hi,
                                             input logic [CNT_W-1:0] per);
    logic [PW-1:0] h4, p1, p2, p3;
    h4 = {1'b0, hi, 2'b00};
    p1 = {3'b000, per};
    p2 = {2'b00, per, 1'b0};
    p3 = p1 + p2;
    if      (h4 >= p3) quant_level = 2'd3;
    else if (h4 >= p2) quant_level = 2'd2;
    else if (h4 >= p1) quant_level = 2'd1;
    else               quant_level = 2'd0;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic [2:0]       prm_q;
  logic             rise, fall, tmo_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic             cap_stb_q, cap_stb_d;
  logic [CNT_W-1:0] cper_q, cper_d;
  logic [CNT_W-1:0] chigh_q, chigh_d;
  logic             vld_p0;
  logic [1:0]       lvl_p0;
  logic [CNT_W-1:0] per_p0, high_p0;
  logic             valid_q, stuck_q;
  logic [2:0]       level_q;
  logic [CNT_W-1:0] high_q, per_q;

  // Edges are qualified by prm_q[2] so the reset value of s3 is never
  // mistaken for a real sample: a line already high when reset releases
  // must not look like a rising edge.
  always_comb begin
    rise    = s2_q & ~s3_q & prm_q[2];
    fall    = ~s2_q & s3_q & prm_q[2];
    tmo_hit = (tcnt_q == TMO) & ~rise;
    cnt_d   = rise ? CNT_ONE : sat_inc(cnt_q);
    tcnt_d  = (rise | tmo_hit) ? CNT_ZERO : tcnt_q + CNT_ONE;
  end

  always_comb begin
    state_d   = state_q;
    hcap_d    = hcap_q;
    cap_stb_d = 1'b0;
    cper_d    = cper_q;
    chigh_d   = chigh_q;
    if (tmo_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rise) state_d = ST_HIGH;
        ST_HIGH: begin
          if (fall) begin
            hcap_d  = cnt_q;
            state_d = ST_LOW;
          end else if (rise) begin
            // Missed fall: the whole period counts as high.
            cap_stb_d = 1'b1;
            cper_d    = cnt_q;
            chigh_d   = cnt_q;
          end
        end
        ST_LOW: begin
          if (rise) begin
            cap_stb_d = 1'b1;
            cper_d    = cnt_q;
            chigh_d   = hcap_q;
            state_d   = ST_HIGH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Synchroniser, counters and measurement FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      prm_q     <= 3'b000;
      cnt_q     <= CNT_ZERO;
      tcnt_q    <= CNT_ZERO;
      state_q   <= ST_IDLE;
      hcap_q    <= CNT_ZERO;
      cap_stb_q <= 1'b0;
      cper_q    <= CNT_ZERO;
      chigh_q   <= CNT_ZERO;
    end else begin
      s1_q      <= pwm_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      prm_q     <= {prm_q[1:0], 1'b1};
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      state_q   <= state_d;
      hcap_q    <= hcap_d;
      cap_stb_q <= cap_stb_d;
      cper_q    <= cper_d;
      chigh_q   <= chigh_d;
    end
  end

  // p0: duty quantisation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0  <= 1'b0;
      lvl_p0  <= 2'd0;
      per_p0  <= CNT_ZERO;
      high_p0 <= CNT_ZERO;
    end else begin
      vld_p0  <= cap_stb_q;
      lvl_p0  <= quant_level(chigh_q, cper_q);
      per_p0  <= cper_q;
      high_p0 <= chigh_q;
    end
  end

  // p1: published result; a stuck event bypasses the quantiser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      level_q <= 3'd0;
      high_q  <= CNT_ZERO;
      per_q   <= CNT_ZERO;
    end else if (tmo_hit) begin
      valid_q <= 1'b1;
      stuck_q <= 1'b1;
      level_q <= s2_q ? 3'd4 : 3'd0;
      high_q  <= CNT_ZERO;
      per_q   <= CNT_ZERO;
    end else if (vld_p0) begin
      valid_q <= 1'b1;
      stuck_q <= 1'b0;
      level_q <= {1'b0, lvl_p0};
      high_q  <= high_p0;
      per_q   <= per_p0;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid      = valid_q;
  assign level      = level_q;
  assign high_cnt   = high_q;
  assign period_cnt = per_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 1000;

  logic             clk;
  logic             reset_n;
  logic             pwm_in;
  logic             valid;
  logic [2:0]       level;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             stuck;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwm_in     (pwm_in),
    .valid      (valid),
    .level      (level),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .stuck      (stuck)
  );

  typedef struct {
    int lvl;
    int hi;
    int per;
    int stk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  bit   prev_ok    = 1'b0;
  int   prev_h     = 0;
  int   prev_p     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Duty model: min(3, floor(4h/p)).
  function automatic int exp_level(input int h, input int p);
    int q;
    q = (4 * h) / p;
    return (q > 3) ? 3 : q;
  endfunction

  task automatic push(input int lvl, input int hi, input int per, input int stk, input int at);
    exp_t e;
    e.lvl = lvl; e.hi = hi; e.per = per; e.stk = stk; e.cyc = at;
    sb.push_back(e);
  endtask

  // One PWM period starting with a rise now; the rise completes the
  // previous period, whose result appears 5 edges later in cyc terms.
  task automatic run_period(input int h, input int p);
    if (prev_ok) push(exp_level(prev_h, prev_p), prev_h, prev_p, 0, cyc + 5);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
    prev_ok = 1'b1;
    prev_h  = h;
    prev_p  = p;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},  {31'd0, valid},      32'd0);
    chk({tag, "_level"},  {29'd0, level},      32'd0);
    chk({tag, "_high"},   {20'd0, high_cnt},   32'd0);
    chk({tag, "_period"}, {20'd0, period_cnt}, 32'd0);
    chk({tag, "_stuck"},  {31'd0, stuck},      32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    pwm_in  = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (valid === 1'b1) begin
          chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("level",      {29'd0, level},      e.lvl);
            chk("high_cnt",   {20'd0, high_cnt},   e.hi);
            chk("period_cnt", {20'd0, period_cnt}, e.per);
            chk("stuck",      {31'd0, stuck},      e.stk);
            chk("valid_cycle", cyc,                e.cyc);
          end
        end
      end
    join_none

    // Reset with the line low, then two stuck-low strobes.
    tick(3);
    chk_zero_outputs("in_reset");
    reset_n = 1'b1;
    push(0, 0, 0, 1, cyc + TIMEOUT + 1);
    push(0, 0, 0, 1, cyc + 2 * (TIMEOUT + 1));
    tick(1);
    chk_zero_outputs("after_reset");
    tick(2 * (TIMEOUT + 1) + 7);

    // Periodic P=100, H=25, then a duty sweep.
    prev_ok = 1'b0;
    run_period(25, 100);
    run_period(25, 100);
    run_period(25, 100);
    run_period(24, 100);
    run_period(50, 100);
    run_period(74, 100);
    run_period(75, 100);
    run_period(99, 100);

    // Line stuck high after a full period.
    push(exp_level(prev_h, prev_p), prev_h, prev_p, 0, cyc + 5);
    push(4, 0, 0, 1, cyc + 3 + TIMEOUT + 1);
    push(4, 0, 0, 1, cyc + 3 + 2 * (TIMEOUT + 1));
    pwm_in = 1'b1;
    tick(2 * (TIMEOUT + 1) + 8);

    // Resume PWM: results only after two rises.
    pwm_in = 1'b0;
    tick(20);
    prev_ok = 1'b0;
    run_period(30, 100);
    run_period(30, 100);
    run_period(40, 100);

    // Reset pulsed during the HIGH phase of P=100/H=40.
    push(exp_level(prev_h, prev_p), prev_h, prev_p, 0, cyc + 5);
    pwm_in = 1'b1;
    tick(10);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    tick(3);
    reset_n = 1'b1;
    tick(27);
    pwm_in = 1'b0;
    tick(60);
    prev_ok = 1'b0;
    run_period(40, 100);
    run_period(40, 100);
    push(exp_level(prev_h, prev_p), prev_h, prev_p, 0, cyc + 5);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(20);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the LED PWM generator. Samples an external PWM waveform and measures period and high time in clock cycles.
- Quantises duty cycle into the 0..4 brightness scale used by the generator. Publishes one result per PWM period with a single-cycle valid strobe.
- Flags a stuck line (no rising edge within TIMEOUT cycles). Sits between a board pin or loopback PWM and status/LED logic.

Parameters:
- CNT_W, 20, width of the cycle counters and of high_cnt/period_cnt.
- TIMEOUT, 1000000, cycles without a rising edge before a stuck event; must be less than 2**CNT_W.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pwm_in  input  1  asynchronous PWM waveform
- valid  output  1  one-cycle strobe; new level/high_cnt/period_cnt/stuck presented this cycle
- level  output  3  quantised duty 0..4
- high_cnt  output  CNT_W  high time of last complete period, in cycles
- period_cnt  output  CNT_W  rise-to-rise period, in cycles
- stuck  output  1  1 = last result was a timeout event

Behaviour:
- Reset (reset_n low, asynchronous): clears all registers. Outputs: valid=0, level=0, high_cnt=0, period_cnt=0, stuck=0, FSM=IDLE.
- Input path:
  - Two-flop synchroniser s1->s2, plus a previous-value flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - No debounce; every synchronised edge counts.
- Counting:
  - Counter cnt increments every cycle and saturates at 2**CNT_W-1.
  - On a rise-detect cycle, cnt loads 1.
  - For an input of period P cycles and high time H cycles, results are period_cnt=P and high_cnt=H exactly.
- FSM states:
  - IDLE: wait for first rise after reset or a stuck event; no measurement output. On rise -> HIGH.
  - HIGH: on fall, latch hcap=cnt -> LOW.
  - LOW: on rise, capture period=cnt and high=hcap, raise internal cap_stb -> HIGH (cnt restarts at 1).
- Output stage (registered, one cycle after cap_stb):
  - valid=1 for one cycle. period_cnt and high_cnt updated, stuck=0.
  - level = largest k in 0..3 with 4*high >= k*period.
  - Products computed at CNT_W+3 bits; no overflow permitted.
  - All outputs hold until the next valid.
- Latency: pwm_in rising before clock edge n -> valid high after edge n+4.
- Timeout:
  - Separate counter tcnt, cleared on reset, on every rise, and on every stuck event; increments otherwise.
  - When tcnt reaches TIMEOUT in any state, the next edge produces: valid=1, stuck=1, high_cnt=0, period_cnt=0.
  - level=4 if s2=1, else level=0.
  - FSM -> IDLE; tcnt cleared, so stuck events repeat every TIMEOUT+1 cycles while the line is static.
- Simultaneous events:
  - rise and tcnt==TIMEOUT in the same cycle: rise wins; no stuck event.
  - rise in HIGH state (fall missed) is impossible by construction; if it occurs, treat it as LOW->HIGH with high=period.
- level 4 is produced only by a stuck-high event. A measured period never yields 4.
- Reset mid-period discards partial measurement; first valid comes only after two new rises or a timeout.

Test Plan (CNT_W=12, TIMEOUT=1000):
- Reset with pwm_in=0 -> all outputs 0 during and immediately after reset; no valid before cycle 1000.
- Periodic P=100, H=25 -> first valid 4 cycles after second rise; period_cnt=100, high_cnt=25, level=1, stuck=0. Repeats every 100 cycles.
- Sweep with P=100: H=24 -> level 0; H=50 -> level 2; H=74 -> level 2; H=75 -> level 3; H=99 -> level 3.
- Hold pwm_in=1 after one full period -> valid with stuck=1, level=4, counts 0 at TIMEOUT+1 cycles after last rise (+1 pipeline); repeats every 1001 cycles. Resuming PWM -> IDLE, normal results after two rises.
- pwm_in=0 from reset -> stuck=1, level=0 strobes every 1001 cycles.
- reset_n pulsed low during the HIGH phase of P=100/H=40 -> outputs zero asynchronously; next valid reports period_cnt=100, high_cnt=40, level=1 only after two post-reset rises.
